axonerve_burst_reader: RTL and testbench

AXONERVE_BURST_READER -- requirements
Module: axonerve_burst_reader

---
 rtl/axonerve_burst_reader.sv | 192 +++++++++++++++++++
 tb/tb_axonerve_burst_reader.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axonerve_burst_reader.sv
// AXI4 burst reader: splits a beat-count request into 4 KB-safe bursts of at most
// C_MAX_BURST_LEN beats and forwards read data straight to an output stream.
module axonerve_burst_reader #(
  parameter int C_M_AXI_ADDR_WIDTH = 64,
  parameter int C_M_AXI_DATA_WIDTH = 512,
  parameter int C_MAX_BURST_LEN    = 16
) (
  input  logic                          ap_clk,
  input  logic                          ap_rst,
  input  logic                          ap_start,
  output logic                          ap_idle,
  output logic                          ap_done,
  input  logic [31:0]                   data_num,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] axi_ptr,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]                    m_axi_arlen,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic                          m_axi_rlast,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0] out_data,
  output logic                          out_last,
  output logic                          error
);

  localparam int          BYTES_PER_BEAT = C_M_AXI_DATA_WIDTH / 8;
  localparam int          BEAT_SHIFT     = $clog2(BYTES_PER_BEAT);
  localparam logic [31:0] MAX_LEN        = 32'(C_MAX_BURST_LEN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                          state_r;
  state_t                          state_s;
  logic [31:0]                     remaining_r;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_r;
  logic [8:0]                      burst_beats_r;
  logic [8:0]                      beat_cnt_r;
  logic                            error_r;
  logic                            ap_done_r;

  logic [12:0]                     to_boundary_bytes_s;
  logic [31:0]                     to_boundary_beats_s;
  logic [31:0]                     limit_s;
  logic [31:0]                     burst_len_s;
  logic [8:0]                      burst_beats_s;
  logic [7:0]                      arlen_s;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_step_s;
  logic                            accept_s;
  logic                            last_in_burst_s;

  // Room left before the next 4 KB page; addr is beat-aligned so this is never zero.
  assign to_boundary_bytes_s = 13'd4096 - {1'b0, addr_r[11:0]};
  assign to_boundary_beats_s = {19'd0, to_boundary_bytes_s} >> BEAT_SHIFT;

  // Burst length is the smallest of what is left, the burst cap and the page room.
  always_comb begin
    limit_s     = MAX_LEN;
    burst_len_s = MAX_LEN;
    if (remaining_r < MAX_LEN) begin
      limit_s = remaining_r;
    end else begin
      limit_s = MAX_LEN;
    end
    if (to_boundary_beats_s < limit_s) begin
      burst_len_s = to_boundary_beats_s;
    end else begin
      burst_len_s = limit_s;
    end
  end

  assign burst_beats_s   = burst_len_s[8:0];
  assign arlen_s         = 8'(burst_len_s - 32'd1);
  assign addr_step_s     = C_M_AXI_ADDR_WIDTH'(burst_beats_r) << BEAT_SHIFT;
  assign accept_s        = (state_r == DATA) && m_axi_rvalid && out_ready;
  assign last_in_burst_s = (beat_cnt_r == 9'd1);

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (ap_start) begin
          if (data_num == 32'd0) begin
            state_s = DONE;
          end else begin
            state_s = ADDR;
          end
        end else begin
          state_s = IDLE;
        end
      end
      ADDR: begin
        if (m_axi_arready) begin
          state_s = DATA;
        end else begin
          state_s = ADDR;
        end
      end
      DATA: begin
        if (accept_s && last_in_burst_s) begin
          if (remaining_r == 32'd1) begin
            state_s = DONE;
          end else begin
            state_s = ADDR;
          end
        end else begin
          state_s = DATA;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Transfer bookkeeping: remaining beats, address, in-burst counter, sticky error.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      remaining_r   <= 32'd0;
      addr_r        <= {C_M_AXI_ADDR_WIDTH{1'b0}};
      burst_beats_r <= 9'd0;
      beat_cnt_r    <= 9'd0;
      error_r       <= 1'b0;
      ap_done_r     <= 1'b0;
    end else begin
      ap_done_r <= (state_r == DONE);
      case (state_r)
        IDLE: begin
          if (ap_start) begin
            remaining_r <= data_num;
            addr_r      <= axi_ptr;
            error_r     <= 1'b0;
          end
        end
        ADDR: begin
          if (m_axi_arready) begin
            burst_beats_r <= burst_beats_s;
            beat_cnt_r    <= burst_beats_s;
          end
        end
        DATA: begin
          if (accept_s) begin
            remaining_r <= remaining_r - 32'd1;
            beat_cnt_r  <= beat_cnt_r - 9'd1;
            // rlast must line up with our own count; a mismatch is flagged but never trusted.
            if (m_axi_rlast != last_in_burst_s) begin
              error_r <= 1'b1;
            end
            if (last_in_burst_s) begin
              addr_r <= addr_r + addr_step_s;
            end
          end
        end
        DONE: begin
          remaining_r <= remaining_r;
        end
        default: begin
          remaining_r <= 32'd0;
        end
      endcase
    end
  end

  assign ap_idle       = (state_r == IDLE);
  assign ap_done       = ap_done_r;
  assign error         = error_r;
  assign m_axi_arvalid = (state_r == ADDR);
  assign m_axi_araddr  = m_axi_arvalid ? addr_r : {C_M_AXI_ADDR_WIDTH{1'b0}};
  assign m_axi_arlen   = m_axi_arvalid ? arlen_s : 8'd0;
  assign m_axi_rready  = (state_r == DATA) && out_ready;
  assign out_valid     = (state_r == DATA) && m_axi_rvalid;
  assign out_data      = out_valid ? m_axi_rdata : {C_M_AXI_DATA_WIDTH{1'b0}};
  assign out_last      = out_valid && (remaining_r == 32'd1);

endmodule

// File: tb/tb_axonerve_burst_reader.sv
// Scoreboard bench for axonerve_burst_reader: directed transfers against a behavioural
// AXI read slave; expected bursts and beats are queued at issue and checked by a monitor.
module tb_axonerve_burst_reader;

  localparam int AW = 64;
  localparam int DW = 512;

  logic          ap_clk = 1'b0;
  logic          ap_rst;
  logic          ap_start;
  logic          ap_idle;
  logic          ap_done;
  logic [31:0]   data_num;
  logic [AW-1:0] axi_ptr;
  logic          m_axi_arvalid;
  logic          m_axi_arready;
  logic [AW-1:0] m_axi_araddr;
  logic [7:0]    m_axi_arlen;
  logic          m_axi_rvalid;
  logic          m_axi_rready;
  logic [DW-1:0] m_axi_rdata;
  logic          m_axi_rlast;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          error;

  axonerve_burst_reader #(
    .C_M_AXI_ADDR_WIDTH(AW),
    .C_M_AXI_DATA_WIDTH(DW),
    .C_MAX_BURST_LEN(16)
  ) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start), .ap_idle(ap_idle),
    .ap_done(ap_done), .data_num(data_num), .axi_ptr(axi_ptr),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rlast(m_axi_rlast),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .error(error)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct { logic [DW-1:0] data; logic last; } beat_t;
  typedef struct { logic [AW-1:0] addr; logic [7:0] len; } ar_t;

  beat_t exp_out[$];
  ar_t   exp_ar[$];
  int    chk_cnt  = 0;
  int    pass_cnt = 0;
  logic  rdy_rand   = 1'b0;
  logic  inject_err = 1'b0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    chk_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: actual %0h required %0h", name, act, req);
  endtask

  function automatic logic [DW-1:0] beat_data(input logic [AW-1:0] a);
    return {8{a ^ 64'hA5A5_0000_5A5A_0000}};
  endfunction

  task automatic push_ar(input logic [AW-1:0] a, input logic [7:0] len);
    ar_t r;
    r.addr = a;
    r.len  = len;
    exp_ar.push_back(r);
  endtask

  task automatic expect_xfer(input logic [AW-1:0] ptr, input int num);
    for (int i = 0; i < num; i++) begin
      beat_t b;
      b.data = beat_data(ptr + 64'(i) * 64'd64);
      b.last = (i == num - 1);
      exp_out.push_back(b);
    end
  endtask

  task automatic pulse_start(input logic [AW-1:0] ptr, input logic [31:0] num);
    @(posedge ap_clk); #1;
    axi_ptr  = ptr;
    data_num = num;
    ap_start = 1'b1;
    @(posedge ap_clk); #1;
    ap_start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    @(negedge ap_clk);
    while (n < budget && !ap_done) begin
      @(negedge ap_clk);
      n++;
    end
    check("done_seen", ap_done, 1'b1);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_idle"},    ap_idle, 1'b1);
    check({tag, "_done"},    ap_done, 1'b0);
    check({tag, "_arvalid"}, m_axi_arvalid, 1'b0);
    check({tag, "_araddr"},  m_axi_araddr, 64'd0);
    check({tag, "_arlen"},   m_axi_arlen, 8'd0);
    check({tag, "_rready"},  m_axi_rready, 1'b0);
    check({tag, "_ovalid"},  out_valid, 1'b0);
    check({tag, "_odata"},   out_data, {DW{1'b0}});
    check({tag, "_olast"},   out_last, 1'b0);
    check({tag, "_error"},   error, 1'b0);
  endtask

  // Output-ready driver: either held high or randomly toggled.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge ap_clk); #1;
      out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Behavioural AXI read slave with random arready/rvalid gaps.
  initial begin
    logic          ar_hs, r_hs;
    logic [AW-1:0] cap_addr, cur_addr;
    logic [7:0]    cap_len;
    int            beats_left, beat_idx, burst_len;
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_rdata = '0;
    beats_left = 0; beat_idx = 0; burst_len = 0; cur_addr = '0;
    forever begin
      @(negedge ap_clk);
      ar_hs    = m_axi_arvalid && m_axi_arready;
      r_hs     = m_axi_rvalid && m_axi_rready;
      cap_addr = m_axi_araddr;
      cap_len  = m_axi_arlen;
      @(posedge ap_clk); #1;
      if (ap_rst) begin
        m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; beats_left = 0;
      end else begin
        if (ar_hs) begin
          cur_addr = cap_addr; burst_len = int'(cap_len) + 1; beats_left = burst_len; beat_idx = 0;
        end
        if (r_hs) begin
          beats_left--; beat_idx++;
        end
        m_axi_arready = (beats_left == 0) && m_axi_arvalid && ($urandom_range(0, 3) != 0);
        if (beats_left > 0 && $urandom_range(0, 3) != 0) begin
          m_axi_rvalid = 1'b1;
          m_axi_rdata  = beat_data(cur_addr + 64'(beat_idx) * 64'd64);
          m_axi_rlast  = (beat_idx == burst_len - 1) || (inject_err && beat_idx == 2);
        end else begin
          m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_rdata = '0;
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever an AR or stream handshake is presented.
  initial begin
    forever begin
      @(negedge ap_clk);
      if (!ap_rst) begin
        if (m_axi_arvalid && m_axi_arready) begin
          check("ar_expected", exp_ar.size() != 0, 1'b1);
          if (exp_ar.size() != 0) begin
            ar_t r;
            r = exp_ar.pop_front();
            check("araddr", m_axi_araddr, r.addr);
            check("arlen", m_axi_arlen, r.len);
          end
        end
        if (out_valid) check("rready_tracks", m_axi_rready, out_ready);
        if (out_valid && out_ready) begin
          check("beat_expected", exp_out.size() != 0, 1'b1);
          if (exp_out.size() != 0) begin
            beat_t b;
            b = exp_out.pop_front();
            check("out_data", out_data, b.data);
            check("out_last", out_last, b.last);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    ap_rst = 1'b1; ap_start = 1'b0; data_num = 32'd0; axi_ptr = '0;
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    check_quiet("reset");
    @(posedge ap_clk); #1;
    ap_rst = 1'b0;

    // Zero-length transfer: no burst, done pulse in the second cycle after the start sample.
    pulse_start(64'h0, 32'd0);
    @(negedge ap_clk);
    check("zero_c1_done", ap_done, 1'b0);
    check("zero_c1_arvalid", m_axi_arvalid, 1'b0);
    @(negedge ap_clk);
    check("zero_c2_done", ap_done, 1'b1);
    check("zero_c2_arvalid", m_axi_arvalid, 1'b0);
    @(negedge ap_clk);
    check("zero_c3_done", ap_done, 1'b0);
    check("zero_c3_idle", ap_idle, 1'b1);

    // 40 beats from a page start: 16 + 16 + 8.
    push_ar(64'h1000, 8'd15); push_ar(64'h1400, 8'd15); push_ar(64'h1800, 8'd7);
    expect_xfer(64'h1000, 40);
    pulse_start(64'h1000, 32'd40);
    wait_done(2000);
    check("x40_error", error, 1'b0);
    @(negedge ap_clk);
    check("x40_done_width", ap_done, 1'b0);
    check("x40_beats_left", exp_out.size(), 0);
    check("x40_ars_left", exp_ar.size(), 0);

    // 4 beats straddling the 0x2000 page boundary.
    push_ar(64'h1F80, 8'd1); push_ar(64'h2000, 8'd1);
    expect_xfer(64'h1F80, 4);
    pulse_start(64'h1F80, 32'd4);
    wait_done(500);
    check("x4b_beats_left", exp_out.size(), 0);
    check("x4b_ars_left", exp_ar.size(), 0);

    // 8 beats with random backpressure.
    rdy_rand = 1'b1;
    push_ar(64'h4000, 8'd7);
    expect_xfer(64'h4000, 8);
    pulse_start(64'h4000, 32'd8);
    wait_done(1000);
    rdy_rand = 1'b0;
    check("x8_beats_left", exp_out.size(), 0);

    // Early rlast on beat 3 of a 16-beat burst: sticky error, flow unchanged.
    inject_err = 1'b1;
    push_ar(64'h0, 8'd15);
    expect_xfer(64'h0, 16);
    pulse_start(64'h0, 32'd16);
    wait_done(1000);
    check("err_at_done", error, 1'b1);
    check("err_beats_left", exp_out.size(), 0);
    @(negedge ap_clk);
    check("err_after_done", error, 1'b1);
    inject_err = 1'b0;
    push_ar(64'h8000, 8'd3);
    expect_xfer(64'h8000, 4);
    pulse_start(64'h8000, 32'd4);
    @(negedge ap_clk);
    check("err_cleared_on_start", error, 1'b0);
    wait_done(500);
    check("err_clear_done", error, 1'b0);

    // Reset in the middle of a 40-beat transfer, then a normal 4-beat transfer.
    push_ar(64'h1000, 8'd15); push_ar(64'h1400, 8'd15); push_ar(64'h1800, 8'd7);
    expect_xfer(64'h1000, 40);
    pulse_start(64'h1000, 32'd40);
    n = 0;
    while (exp_out.size() > 30 && n < 500) begin
      @(negedge ap_clk);
      n++;
    end
    check("rst_reached_data", exp_out.size() <= 30, 1'b1);
    @(posedge ap_clk); #1;
    ap_rst = 1'b1;
    #1;
    check_quiet("rst_mid");
    exp_out.delete();
    exp_ar.delete();
    repeat (2) @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge ap_clk);
      check("rst_no_done", ap_done, 1'b0);
    end
    push_ar(64'h1000, 8'd3);
    expect_xfer(64'h1000, 4);
    pulse_start(64'h1000, 32'd4);
    wait_done(500);
    check("post_rst_error", error, 1'b0);
    check("post_rst_beats_left", exp_out.size(), 0);
    check("post_rst_ars_left", exp_ar.size(), 0);

    repeat (3) @(negedge ap_clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
